// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: WB results win, MDU results are
// buffered in a small FIFO and drained into idle write slots.
module wb_write_arbiter #(
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int BUF_DEPTH           = 2,
    parameter int STARVE_LIMIT        = 4,
    localparam int CW = $clog2(BUF_DEPTH) + 1,
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           reg_write_WB,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_WB,
    input  logic [DATA_WIDTH-1:0]          result_WB,
    input  logic                           mdu_valid,
    output logic                           mdu_ready,
    input  logic [REGISTER_ADDR_WIDTH-1:0] mdu_rd,
    input  logic [DATA_WIDTH-1:0]          mdu_result,
    output logic                           rf_we,
    output logic [REGISTER_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]          rf_wdata,
    output logic                           stall_req,
    output logic [CW-1:0]                  buf_count
);

    logic [REGISTER_ADDR_WIDTH-1:0] addr_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0]          data_q [BUF_DEPTH];
    logic [PW-1:0]                  rd_ptr;
    logic [PW-1:0]                  wr_ptr;
    logic [SW-1:0]                  starve_cnt;

    logic wb_eff;
    logic fifo_empty;
    logic push;
    logic pop;

    assign wb_eff     = reg_write_WB && (rd_WB != '0);
    assign fifo_empty = (buf_count == '0);
    assign mdu_ready  = !rst && (buf_count < CW'(BUF_DEPTH));
    // Accepted x0 results are dropped rather than occupying a slot.
    assign push       = mdu_valid && mdu_ready && (mdu_rd != '0);
    assign pop        = !wb_eff && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= mdu_rd;
            data_q[wr_ptr] <= mdu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            stall_req  <= 1'b0;
            buf_count  <= '0;
            starve_cnt <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            rf_we <= wb_eff || pop;
            if (wb_eff) begin
                rf_waddr <= rd_WB;
                rf_wdata <= result_WB;
            end else if (pop) begin
                rf_waddr <= addr_q[rd_ptr];
                rf_wdata <= data_q[rd_ptr];
            end

            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   buf_count <= buf_count + CW'(1);
                2'b01:   buf_count <= buf_count - CW'(1);
                default: buf_count <= buf_count;
            endcase

            // Counter runs only while a head entry is waiting unserved.
            if (fifo_empty || pop) begin
                starve_cnt <= '0;
                stall_req  <= 1'b0;
            end else begin
                if (starve_cnt < SW'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + SW'(1);
                if (starve_cnt == SW'(STARVE_LIMIT))
                    stall_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_WB;
    logic [4:0]  rd_WB;
    logic [31:0] result_WB;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [1:0]  buf_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_write_arbiter #(
        .DATA_WIDTH(32),
        .REGISTER_ADDR_WIDTH(5),
        .BUF_DEPTH(2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .reg_write_WB(reg_write_WB),
        .rd_WB(rd_WB),
        .result_WB(result_WB),
        .mdu_valid(mdu_valid),
        .mdu_ready(mdu_ready),
        .mdu_rd(mdu_rd),
        .mdu_result(mdu_result),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .stall_req(stall_req),
        .buf_count(buf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd,
                      input logic [31:0] d);
        reg_write_WB = we;
        rd_WB        = rd;
        result_WB    = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] rd,
                       input logic [31:0] d);
        mdu_valid  = v;
        mdu_rd     = rd;
        mdu_result = d;
    endtask

    initial begin
        rst = 1'b1;
        wb(1'b1, 5'd5, 32'h1111);
        mdu(1'b1, 5'd7, 32'h2222);
        #1;
        chk("rst_ready", 32'(mdu_ready), 0);
        step();
        chk("rst_we1", 32'(rf_we), 0);
        chk("rst_cnt1", 32'(buf_count), 0);
        step();
        chk("rst_we2", 32'(rf_we), 0);
        chk("rst_stall", 32'(stall_req), 0);
        chk("rst_cnt2", 32'(buf_count), 0);
        chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_ready2", 32'(mdu_ready), 0);
        rst = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        mdu(1'b0, 5'd0, 32'h0);
        #1;
        chk("rel_ready", 32'(mdu_ready), 1);

        // WB only
        wb(1'b1, 5'd5, 32'h1234);
        step();
        chk("wb_we", 32'(rf_we), 1);
        chk("wb_waddr", 32'(rf_waddr), 5);
        chk("wb_wdata", rf_wdata, 32'h1234);
        wb(1'b1, 5'd0, 32'h5555);
        step();
        chk("x0_we", 32'(rf_we), 0);
        chk("x0_waddr", 32'(rf_waddr), 5);
        chk("x0_wdata", rf_wdata, 32'h1234);

        // MDU idle drain
        wb(1'b0, 5'd0, 32'h0);
        mdu(1'b1, 5'd7, 32'hDEAD);
        step();
        mdu(1'b0, 5'd0, 32'h0);
        chk("idle_n1_we", 32'(rf_we), 0);
        chk("idle_n1_cnt", 32'(buf_count), 1);
        step();
        chk("idle_n2_we", 32'(rf_we), 1);
        chk("idle_n2_waddr", 32'(rf_waddr), 7);
        chk("idle_n2_wdata", rf_wdata, 32'hDEAD);
        chk("idle_n2_cnt", 32'(buf_count), 0);

        // Collision and starvation
        wb(1'b1, 5'd3, 32'h33);
        mdu(1'b1, 5'd9, 32'h99);
        step();
        mdu(1'b0, 5'd0, 32'h0);
        chk("col_cnt", 32'(buf_count), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("col_waddr", 32'(rf_waddr), 3);
            chk("col_stall_lo", 32'(stall_req), 0);
            step();
        end
        chk("col_n5_stall", 32'(stall_req), 0);
        chk("col_n5_waddr", 32'(rf_waddr), 3);
        step();
        chk("col_n6_stall", 32'(stall_req), 1);
        chk("col_n6_cnt", 32'(buf_count), 1);
        wb(1'b0, 5'd3, 32'h33);
        step();
        chk("col_drain_we", 32'(rf_we), 1);
        chk("col_drain_waddr", 32'(rf_waddr), 9);
        chk("col_drain_wdata", rf_wdata, 32'h99);
        chk("col_drain_stall", 32'(stall_req), 0);
        chk("col_drain_cnt", 32'(buf_count), 0);

        // Full FIFO and pointer wrap
        wb(1'b1, 5'd3, 32'h33);
        mdu(1'b1, 5'd10, 32'hA0);
        step();
        chk("full_cnt1", 32'(buf_count), 1);
        chk("full_rdy1", 32'(mdu_ready), 1);
        mdu(1'b1, 5'd11, 32'hB1);
        step();
        chk("full_cnt2", 32'(buf_count), 2);
        chk("full_rdy2", 32'(mdu_ready), 0);
        mdu(1'b1, 5'd12, 32'hC2);
        step();
        chk("full_held_cnt", 32'(buf_count), 2);
        chk("full_held_rdy", 32'(mdu_ready), 0);
        chk("full_held_waddr", 32'(rf_waddr), 3);
        wb(1'b0, 5'd0, 32'h0);
        step();
        chk("wrap_w10_addr", 32'(rf_waddr), 10);
        chk("wrap_w10_data", rf_wdata, 32'hA0);
        chk("wrap_rdy", 32'(mdu_ready), 1);
        step();
        mdu(1'b0, 5'd0, 32'h0);
        chk("wrap_w11_addr", 32'(rf_waddr), 11);
        chk("wrap_w11_data", rf_wdata, 32'hB1);
        chk("wrap_pp_cnt", 32'(buf_count), 1);
        step();
        chk("wrap_w12_we", 32'(rf_we), 1);
        chk("wrap_w12_addr", 32'(rf_waddr), 12);
        chk("wrap_w12_data", rf_wdata, 32'hC2);
        chk("wrap_cnt0", 32'(buf_count), 0);

        // MDU x0 discard
        mdu(1'b1, 5'd0, 32'hBAD);
        #1;
        chk("x0m_ready", 32'(mdu_ready), 1);
        step();
        mdu(1'b0, 5'd0, 32'h0);
        chk("x0m_cnt", 32'(buf_count), 0);
        chk("x0m_we", 32'(rf_we), 0);
        step();
        chk("x0m_we2", 32'(rf_we), 0);
        chk("x0m_waddr", 32'(rf_waddr), 12);

        // Push while popping at count 1
        mdu(1'b1, 5'd13, 32'hD13);
        step();
        chk("pp_cnt1", 32'(buf_count), 1);
        mdu(1'b1, 5'd14, 32'hE14);
        step();
        mdu(1'b0, 5'd0, 32'h0);
        chk("pp_cnt_hold", 32'(buf_count), 1);
        chk("pp_w13", 32'(rf_waddr), 13);
        chk("pp_d13", rf_wdata, 32'hD13);
        step();
        chk("pp_w14", 32'(rf_waddr), 14);
        chk("pp_d14", rf_wdata, 32'hE14);
        chk("pp_cnt0", 32'(buf_count), 0);

        // Reset mid-operation flushes the buffer
        wb(1'b1, 5'd3, 32'h33);
        mdu(1'b1, 5'd15, 32'hF15);
        step();
        mdu(1'b0, 5'd0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        chk("flush_cnt_pre", 32'(buf_count), 1);
        rst = 1'b1;
        step();
        chk("flush_cnt", 32'(buf_count), 0);
        chk("flush_we", 32'(rf_we), 0);
        rst = 1'b0;
        step();
        chk("flush_no_write", 32'(rf_we), 0);
        chk("flush_cnt2", 32'(buf_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
